// File: rtl/token_sched_pkg.sv
// Shared constants, channel index type and the round-robin search helper
// for the token decimation scheduler.
package token_sched_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_RATIO_W = 4;
  localparam int DEF_PEND_W  = 3;
  localparam int CH_W        = $clog2(DEF_N_CH);

  // Ratio every channel returns to on reset: keep one token in two.
  localparam int RATIO_RST = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  // First requesting channel strictly after ptr, wrapping; ptr itself is
  // searched last. Returns 0 when nothing requests.
  function automatic ch_idx_t next_req(input logic [DEF_N_CH-1:0] req,
                                       input ch_idx_t ptr);
    ch_idx_t sel;
    logic    found;
    int      idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= DEF_N_CH; k++) begin
      idx = (int'(ptr) + k) % DEF_N_CH;
      if (!found && req[idx]) begin
        sel   = ch_idx_t'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/token_decimation_scheduler_if.sv
// Token inputs, ratio configuration and the tagged valid/ready output.
// Handshake: a token moves to the consumer in any cycle where out_valid and
// out_ready are both high; once offered, out_valid stays high and out_ch
// stays fixed until that transfer happens.
interface token_decimation_scheduler_if
  import token_sched_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int RATIO_W = DEF_RATIO_W
);
  logic [N_CH-1:0]    a;
  logic               cfg_we;
  ch_idx_t            cfg_ch;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               out_valid;
  ch_idx_t            out_ch;
  logic               out_ready;
  logic [N_CH-1:0]    drop;

  modport master (
    output a, cfg_we, cfg_ch, cfg_ratio, out_ready,
    input  out_valid, out_ch, drop
  );

  modport slave (
    input  a, cfg_we, cfg_ch, cfg_ratio, out_ready,
    output out_valid, out_ch, drop
  );
endinterface

// File: rtl/token_decim_ch.sv
// One channel: programmable 1-in-R decimator feeding a saturating count of
// kept tokens waiting for the arbiter, with a one-cycle drop pulse on overflow.
module token_decim_ch
  import token_sched_pkg::*;
#(
  parameter int RATIO_W = DEF_RATIO_W,
  parameter int PEND_W  = DEF_PEND_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tok,
  input  logic               i_cfg_we,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  input  logic               i_grant,
  output logic               o_pend_nz,
  output logic               o_drop
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [RATIO_W-1:0] r_ratio;
  logic [RATIO_W-1:0] r_phase;
  logic [PEND_W-1:0]  r_pend;
  logic               r_drop;

  logic w_tok;
  logic w_kept;
  logic w_full;

  // A token counts only on an enabled channel that is not being reconfigured.
  assign w_tok  = i_tok & ~i_cfg_we & (r_ratio != '0);
  assign w_kept = w_tok & (r_phase == (r_ratio - RATIO_W'(1)));
  assign w_full = (r_pend == PEND_MAX);

  // Ratio register and decimation phase; a config write restarts the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ratio <= RATIO_W'(RATIO_RST);
      r_phase <= '0;
    end else if (i_cfg_we) begin
      r_ratio <= i_cfg_ratio;
      r_phase <= '0;
    end else if (w_tok) begin
      r_phase <= w_kept ? '0 : r_phase + RATIO_W'(1);
    end
  end

  // Pending count: kept tokens in, granted tokens out, overflow reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case ({w_kept, i_grant})
        2'b10: begin
          if (w_full) r_drop <= 1'b1;
          else        r_pend <= r_pend + PEND_W'(1);
        end
        2'b01:   r_pend <= r_pend - PEND_W'(1);
        default: ;
      endcase
    end
  end

  assign o_pend_nz = |r_pend;
  assign o_drop    = r_drop;

endmodule

// File: rtl/token_decimation_scheduler.sv
// Shares one tagged token output among N_CH decimated token inputs using a
// round-robin arbiter that holds its choice while the consumer stalls.
module token_decimation_scheduler
  import token_sched_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int RATIO_W = DEF_RATIO_W,
  parameter int PEND_W  = DEF_PEND_W
) (
  input  logic                         clk,
  input  logic                         rst,
  token_decimation_scheduler_if.slave  bus
);

  logic [N_CH-1:0] w_req;
  logic [N_CH-1:0] w_grant;
  logic [N_CH-1:0] w_drop;
  logic [N_CH-1:0] w_cfg_sel;

  ch_idx_t r_rr;
  ch_idx_t r_lock_ch;
  logic    r_lock;

  ch_idx_t w_pick;
  ch_idx_t w_out_ch;
  logic    w_any;
  logic    w_xfer;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_cfg_sel[i] = bus.cfg_we && (bus.cfg_ch == ch_idx_t'(i));
    assign w_grant[i]   = w_xfer && (w_out_ch == ch_idx_t'(i));

    token_decim_ch #(
      .RATIO_W (RATIO_W),
      .PEND_W  (PEND_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_tok       (bus.a[i]),
      .i_cfg_we    (w_cfg_sel[i]),
      .i_cfg_ratio (bus.cfg_ratio),
      .i_grant     (w_grant[i]),
      .o_pend_nz   (w_req[i]),
      .o_drop      (w_drop[i])
    );
  end

  // Output side depends only on registered state, never on the token inputs.
  assign w_any    = |w_req;
  assign w_pick   = next_req(w_req, r_rr);
  assign w_out_ch = r_lock ? r_lock_ch : w_pick;
  assign w_xfer   = w_any & bus.out_ready;

  // Round-robin pointer follows the last served channel; a stalled offer is
  // frozen so the consumer sees a stable tag until it accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr      <= ch_idx_t'(N_CH - 1);
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_rr   <= w_out_ch;
      r_lock <= 1'b0;
    end else if (w_any) begin
      r_lock    <= 1'b1;
      r_lock_ch <= w_out_ch;
    end
  end

  assign bus.out_valid = w_any;
  assign bus.out_ch    = w_out_ch;
  assign bus.drop      = w_drop;

endmodule

// File: tb/tb_token_decimation_scheduler.sv
// Bench for token_decimation_scheduler: directed scenarios plus random
// traffic, all checked against a token-counting reference model.
module tb_token_decimation_scheduler;
  import token_sched_pkg::*;

  localparam int N   = DEF_N_CH;
  localparam int CW  = $clog2(N);
  localparam int CAP = (1 << DEF_PEND_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  token_decimation_scheduler_if bus ();

  token_decimation_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            chk;
    bit            valid;
    int            ch;
    logic [N-1:0]  drop;
  } cyc_t;

  cyc_t           cyc_q[$];
  logic [CW-1:0]  exp_q[$];

  int xfer_cnt[N];
  int drop_cnt[N];
  int log_ch[$];
  int log_cyc[$];
  int cyc_no = 0;

  // Reference model state: tokens counted since last keep, pending counts,
  // the channel currently held on the output and the last channel served.
  int           m_ratio[N];
  int           m_cnt[N];
  int           m_pend[N];
  int           m_held;
  int           m_last;
  bit           m_known = 1'b0;
  logic [N-1:0] m_drop_next;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_ratio[i] = RATIO_RST;
      m_cnt[i]   = 0;
      m_pend[i]  = 0;
    end
    m_held      = -1;
    m_last      = N - 1;
    m_drop_next = '0;
    m_known     = 1'b1;
  endfunction

  // One clock of the model, given the inputs applied for this cycle.
  function automatic void model_step(input logic [N-1:0] a, input bit we, input int cch,
                                     input int cratio, input bit ready, input bit r);
    cyc_t         e;
    bit           any;
    int           ch;
    int           granted;
    bit           kept;
    logic [N-1:0] nd;
    any = 1'b0;
    ch  = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) any = 1'b1;
    if (m_held >= 0) ch = m_held;
    else begin
      for (int k = N; k >= 1; k--) begin
        if (m_pend[(m_last + k) % N] > 0) ch = (m_last + k) % N;
      end
    end
    e.chk   = m_known;
    e.valid = any;
    e.ch    = ch;
    e.drop  = m_drop_next;
    cyc_q.push_back(e);
    if (m_known && any && ready) exp_q.push_back(CW'(ch));
    if (r) begin
      model_reset();
      return;
    end
    if (!m_known) return;
    nd      = '0;
    granted = (any && ready) ? ch : -1;
    for (int i = 0; i < N; i++) begin
      kept = 1'b0;
      if (a[i] && !(we && cch == i) && m_ratio[i] != 0) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_ratio[i]) begin
          kept     = 1'b1;
          m_cnt[i] = 0;
        end
      end
      if (kept && granted == i) ;
      else if (kept) begin
        if (m_pend[i] == CAP) nd[i] = 1'b1;
        else m_pend[i]++;
      end else if (granted == i) m_pend[i]--;
    end
    if (we) begin
      m_ratio[cch] = cratio;
      m_cnt[cch]   = 0;
    end
    if (any && ready) begin
      m_last = ch;
      m_held = -1;
    end else if (any) m_held = ch;
    m_drop_next = nd;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] a, input bit we, input int cch,
                       input int cratio, input bit ready, input bit r);
    @(negedge clk);
    rst           = r;
    bus.a         = a;
    bus.cfg_we    = we;
    bus.cfg_ch    = CW'(cch);
    bus.cfg_ratio = DEF_RATIO_W'(cratio);
    bus.out_ready = ready;
    model_step(a, we, cch, cratio, ready, r);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int k = 0; k < n; k++) drive('0, 1'b0, 0, 0, ready, 1'b0);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      xfer_cnt[i] = 0;
      drop_cnt[i] = 0;
    end
    log_ch.delete();
    log_cyc.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  cyc_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc_no++;
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        if (mon_e.chk) begin
          chk_eq("out_valid", 32'(bus.out_valid), 32'(mon_e.valid));
          if (mon_e.valid) chk_eq("out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
          chk_eq("drop", 32'(bus.drop), 32'(mon_e.drop));
          for (int i = 0; i < N; i++) if (bus.drop[i] === 1'b1) drop_cnt[i]++;
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xfer_cnt[bus.out_ch]++;
            log_ch.push_back(int'(bus.out_ch));
            log_cyc.push_back(cyc_no);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL xfer_unexpected: got ch %0d expected no transfer", bus.out_ch);
            end else begin
              chk_eq("xfer_ch", 32'(bus.out_ch), 32'(exp_q.pop_front()));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.a         = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_ratio = '0;
    bus.out_ready = 1'b0;
    clear_stats();

    drive('0, 1'b0, 0, 0, 1'b0, 1'b1);
    drive('0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(1, 1'b1);
    settle();
    chk_eq("reset_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("reset_ch", 32'(bus.out_ch), 32'd0);
    chk_eq("reset_drop", 32'(bus.drop), 32'd0);

    // Default ratio halves ch0 tokens.
    clear_stats();
    for (int k = 0; k < 4; k++) drive(4'b0001, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(3, 1'b1);
    settle();
    chk_eq("t1_ch0_xfers", 32'(xfer_cnt[0]), 32'd2);

    // Ratio 3 then disabled on ch1.
    clear_stats();
    drive('0, 1'b1, 1, 3, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) drive(4'b0010, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(3, 1'b1);
    settle();
    chk_eq("t2_r3_xfers", 32'(xfer_cnt[1]), 32'd2);
    clear_stats();
    drive('0, 1'b1, 1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) drive(4'b0010, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(3, 1'b1);
    settle();
    chk_eq("t2_r0_xfers", 32'(xfer_cnt[1]), 32'd0);

    // All ratio 1, one burst on every channel after reset: 0,1,2,3 back-to-back.
    drive('0, 1'b0, 0, 0, 1'b1, 1'b1);
    for (int c = 0; c < N; c++) drive('0, 1'b1, c, 1, 1'b1, 1'b0);
    clear_stats();
    drive(4'b1111, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(6, 1'b1);
    settle();
    chk_eq("t3_count", 32'(log_ch.size()), 32'd4);
    if (log_ch.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk_eq("t3_order", 32'(log_ch[k]), 32'(k));
        chk_eq("t3_consecutive", 32'(log_cyc[k] - log_cyc[0]), 32'(k));
      end
    end

    // Saturation on ch2 with the consumer stalled.
    clear_stats();
    for (int k = 0; k < 9; k++) drive(4'b0100, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    settle();
    chk_eq("t4_drops", 32'(drop_cnt[2]), 32'd2);
    idle(10, 1'b1);
    settle();
    chk_eq("t4_xfers", 32'(xfer_cnt[2]), 32'd7);

    // Stalled offer on ch2 is not displaced by a later ch0 token.
    clear_stats();
    drive(4'b0100, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1, 1'b0);
    drive(4'b0001, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    settle();
    chk_eq("t5_held_ch", 32'(bus.out_ch), 32'd2);
    idle(4, 1'b1);
    settle();
    chk_eq("t5_count", 32'(log_ch.size()), 32'd2);
    if (log_ch.size() == 2) begin
      chk_eq("t5_first", 32'(log_ch[0]), 32'd2);
      chk_eq("t5_second", 32'(log_ch[1]), 32'd0);
    end

    // Reset with tokens pending clears outputs and restores ratio 2.
    drive(4'b1111, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 0, 0, 1'b0, 1'b0);
    drive('0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(1, 1'b0);
    settle();
    chk_eq("t6_valid_after_rst", 32'(bus.out_valid), 32'd0);
    clear_stats();
    for (int k = 0; k < 4; k++) drive(4'b1000, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(3, 1'b1);
    settle();
    chk_eq("t6_ratio2_xfers", 32'(xfer_cnt[3]), 32'd2);

    // Random traffic, configuration changes, stalls and rare resets.
    for (int k = 0; k < 800; k++) begin
      drive(N'($urandom_range(0, (1 << N) - 1)),
            ($urandom_range(0, 9) == 0),
            $urandom_range(0, N - 1),
            $urandom_range(0, 5),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0));
    end
    idle(40, 1'b1);
    settle();
    chk_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
